// File: rtl/channel_frame_loader.sv
// Ping-pong frame loader: streams N*N H words (row-major) then N y words into two banks.
// Optional macro FRAME_LAST_CHECK_EN adds s_last/err framing check.
module channel_frame_loader #(
   parameter int unsigned WL = 16,
   parameter int unsigned N  = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [WL-1:0]       s_data,
   input  logic                s_valid,
   output logic                s_ready,
   output logic [WL*N*N-1:0]   Hmatrix_o,
   output logic [WL*N-1:0]     Yarray_o,
   output logic                frame_valid,
   input  logic                frame_ready
`ifdef FRAME_LAST_CHECK_EN
   ,
   input  logic                s_last,
   output logic                err
`endif
);

   localparam int unsigned FRAME_WORDS = N*N + N;
   localparam int unsigned CW          = $clog2(FRAME_WORDS);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} bank_state_t;

   bank_state_t          bank_st [2];
   logic [WL-1:0]        mem [2][FRAME_WORDS];
   logic [CW-1:0]        cnt;
   logic                 wr_bank;
   logic                 rd_bank;

   logic                 accept;
   logic                 last_word;
   logic                 frame_err;
   logic                 fill_done;
   logic                 rel_fire;

   assign s_ready     = (bank_st[wr_bank] == EMPTY);
   assign frame_valid = (bank_st[rd_bank] == FULL);
   assign accept      = s_valid & s_ready;
   assign last_word   = (cnt == CW'(FRAME_WORDS - 1));
   assign rel_fire    = frame_valid & frame_ready;

`ifdef FRAME_LAST_CHECK_EN
   assign frame_err   = accept & (s_last != last_word);
`else
   assign frame_err   = 1'b0;
`endif

   assign fill_done   = accept & last_word & ~frame_err;

   // Fill and release touch different banks, so both may fire on one edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt        <= '0;
         wr_bank    <= 1'b0;
         rd_bank    <= 1'b0;
         bank_st[0] <= EMPTY;
         bank_st[1] <= EMPTY;
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < int'(FRAME_WORDS); i++) begin
               mem[b][i] <= '0;
            end
         end
      end else begin
         if (accept) begin
            mem[wr_bank][cnt] <= s_data;
            cnt <= (last_word || frame_err) ? '0 : cnt + CW'(1);
         end
         if (fill_done) begin
            bank_st[wr_bank] <= FULL;
            wr_bank          <= ~wr_bank;
         end
         if (rel_fire) begin
            bank_st[rd_bank] <= EMPTY;
            rd_bank          <= ~rd_bank;
         end
      end
   end

`ifdef FRAME_LAST_CHECK_EN
   // Sticky framing error; only reset clears it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err <= 1'b0;
      end else if (frame_err) begin
         err <= 1'b1;
      end
   end
`endif

   // Presented bank is unpacked onto the flat H and y buses.
   always_comb begin
      Hmatrix_o = '0;
      Yarray_o  = '0;
      for (int i = 0; i < int'(N*N); i++) begin
         Hmatrix_o[WL*i +: WL] = mem[rd_bank][i];
      end
      for (int r = 0; r < int'(N); r++) begin
         Yarray_o[WL*r +: WL] = mem[rd_bank][N*N + r];
      end
   end

endmodule

// File: tb/tb_channel_frame_loader.sv
// Directed self-checking bench for channel_frame_loader (default N=8, WL=16).
// Define FRAME_LAST_CHECK_EN for both files to exercise the s_last/err path.
module tb_channel_frame_loader;

   localparam int WL = 16;
   localparam int N  = 8;
   localparam int FW = N*N + N;

   logic                clk;
   logic                rst;
   logic [WL-1:0]       s_data;
   logic                s_valid;
   logic                s_ready;
   logic [WL*N*N-1:0]   Hmatrix_o;
   logic [WL*N-1:0]     Yarray_o;
   logic                frame_valid;
   logic                frame_ready;
   logic                s_last;
`ifdef FRAME_LAST_CHECK_EN
   logic                err;
`endif

   int checks   = 0;
   int failures = 0;
   int stalls   = 0;

   channel_frame_loader #(.WL(WL), .N(N)) dut (
      .clk         (clk),
      .rst         (rst),
      .s_data      (s_data),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .Hmatrix_o   (Hmatrix_o),
      .Yarray_o    (Yarray_o),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready)
`ifdef FRAME_LAST_CHECK_EN
      ,
      .s_last      (s_last),
      .err         (err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [WL-1:0] h_at(input int r, input int c);
      return Hmatrix_o[WL*(N*r+c) +: WL];
   endfunction

   function automatic logic [WL-1:0] y_at(input int r);
      return Yarray_o[WL*r +: WL];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One word; waits (bounded) for s_ready, returns 1ns after the accepting edge.
   task automatic send(input logic [WL-1:0] d, input logic last);
      int guard;
      guard   = 0;
      s_data  = d;
      s_last  = last;
      s_valid = 1'b1;
      while (!s_ready && guard < 300) begin
         stalls++;
         guard++;
         step();
      end
      if (!s_ready) check("send_timeout", 64'(s_ready), 64'd1);
      step();
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic send_frame(input int base);
      for (int i = 0; i < FW; i++) send(WL'(base + i), i == FW-1);
   endtask

   initial begin
      rst = 1'b0; s_data = '0; s_valid = 1'b0; s_last = 1'b0; frame_ready = 1'b0;
      #12;
      check("rst_s_ready",     64'(s_ready), 64'd1);
      check("rst_frame_valid", 64'(frame_valid), 64'd0);
      check("rst_H_zero",      64'(Hmatrix_o == '0), 64'd1);
      check("rst_Y_zero",      64'(Yarray_o == '0), 64'd1);
      @(posedge clk); #1; rst = 1'b1;

      // Words 1..72 with frame_ready held high.
      frame_ready = 1'b1;
      for (int i = 0; i < FW; i++) begin
         if (i == FW-1) check("t1_not_early", 64'(frame_valid), 64'd0);
         send(WL'(i + 1), i == FW-1);
      end
      check("t1_valid", 64'(frame_valid), 64'd1);
      check("t1_H00",   64'(h_at(0,0)), 64'd1);
      check("t1_H77",   64'(h_at(7,7)), 64'd64);
      check("t1_y0",    64'(y_at(0)), 64'd65);
      check("t1_y7",    64'(y_at(7)), 64'd72);
      step();
      check("t1_released", 64'(frame_valid), 64'd0);
      frame_ready = 1'b0;

      // Two frames stored, third blocked.
      for (int i = 0; i < 2*FW; i++) send(WL'(i + 1), (i % FW) == FW-1);
      s_valid = 1'b1; s_data = WL'(145);
      step();
      check("t2_blocked", 64'(s_ready), 64'd0);
      check("t2_valid",   64'(frame_valid), 64'd1);
      check("t2_H00_f1",  64'(h_at(0,0)), 64'd1);
      s_valid = 1'b0;
      frame_ready = 1'b1;
      step();
      frame_ready = 1'b0;
      check("t2_valid2",  64'(frame_valid), 64'd1);
      check("t2_H00_f2",  64'(h_at(0,0)), 64'd73);
      check("t2_y7_f2",   64'(y_at(7)), 64'd144);
      check("t2_freed",   64'(s_ready), 64'd1);
      frame_ready = 1'b1;
      step();
      frame_ready = 1'b0;
      check("t2_drained", 64'(frame_valid), 64'd0);

      // Negative values land bit-exact.
      for (int i = 0; i < FW; i++) begin
         if (i == 8*3+5)      send(16'h8000, 1'b0);
         else if (i == 64+2)  send(16'hFFFF, 1'b0);
         else                 send(WL'(i + 1), i == FW-1);
      end
      check("t3_H35",  64'(Hmatrix_o[16*(8*3+5) +: 16]), 64'h8000);
      check("t3_y2",   64'(Yarray_o[16*2 +: 16]), 64'hFFFF);
      check("t3_H34",  64'(h_at(3,4)), 64'd29);
      check("t3_y3",   64'(y_at(3)), 64'd68);
      frame_ready = 1'b1;
      step();
      frame_ready = 1'b0;

      // Reset mid-frame discards the partial fill.
      for (int i = 0; i < 40; i++) send(WL'(500 + i), 1'b0);
      #2 rst = 1'b0;
      #3;
      check("t4_rst_valid", 64'(frame_valid), 64'd0);
      check("t4_rst_ready", 64'(s_ready), 64'd1);
      check("t4_rst_H00",   64'(h_at(0,0)), 64'd0);
      step();
      rst = 1'b1;
      for (int i = 0; i < FW-1; i++) send(WL'(i + 1), 1'b0);
      check("t4_partial", 64'(frame_valid), 64'd0);
      send(WL'(FW), 1'b1);
      check("t4_valid", 64'(frame_valid), 64'd1);
      check("t4_H00",   64'(h_at(0,0)), 64'd1);
      check("t4_y7",    64'(y_at(7)), 64'd72);
      frame_ready = 1'b1;
      step();
      frame_ready = 1'b0;

      // Completion of frame B coincides with release of frame A.
      send_frame(1000);
      for (int i = 0; i < FW-1; i++) send(WL'(2000 + i), 1'b0);
      check("t5_A_H00", 64'(h_at(0,0)), 64'd1000);
      frame_ready = 1'b1;
      send(WL'(2000 + FW-1), 1'b1);
      check("t5_valid", 64'(frame_valid), 64'd1);
      check("t5_B_H00", 64'(h_at(0,0)), 64'd2000);
      check("t5_B_y7",  64'(y_at(7)), 64'd2071);
      step();
      check("t5_drained", 64'(frame_valid), 64'd0);

      // Three back-to-back frames at one word per cycle.
      stalls = 0;
      for (int f = 0; f < 3; f++) send_frame(3000 + 100*f);
      check("t6_no_stall", 64'(stalls), 64'd0);
      check("t6_valid",    64'(frame_valid), 64'd1);
      check("t6_H00",      64'(h_at(0,0)), 64'd3200);
      step();
      frame_ready = 1'b0;
      check("t6_drained",  64'(frame_valid), 64'd0);

`ifdef FRAME_LAST_CHECK_EN
      check("t7_err_clear", 64'(err), 64'd0);
      for (int i = 0; i < 50; i++) send(WL'(i + 1), i == 49);
      check("t7_err_set",   64'(err), 64'd1);
      check("t7_no_valid",  64'(frame_valid), 64'd0);
      send_frame(1);
      check("t7_valid",     64'(frame_valid), 64'd1);
      check("t7_H00",       64'(h_at(0,0)), 64'd1);
      check("t7_y7",        64'(y_at(7)), 64'd72);
      check("t7_err_sticky",64'(err), 64'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/channel_frame_loader.md
CHANNEL_FRAME_LOADER -- requirements
Module: channel_frame_loader

Interface
REQ-001 SHALL have parameter WL, default 16, meaning word length of each signed fixed-point element.
REQ-002 SHALL have parameter N, default 8, meaning matrix dimension (real-valued, N x N H plus N-entry y).
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port s_data  input  WL  streamed signed element.
REQ-006 SHALL have port s_valid  input  1  s_data valid.
REQ-007 SHALL have port s_ready  output  1  loader can accept a word.
REQ-008 SHALL have port Hmatrix_o  output  WL*N*N  packed H frame to the Givens rotation stage.
REQ-009 SHALL have port Yarray_o  output  WL*N  packed y frame.
REQ-010 SHALL have port frame_valid  output  1  Hmatrix_o/Yarray_o hold a complete frame.
REQ-011 SHALL have port frame_ready  input  1  downstream consumes the presented frame.

Function
REQ-012 SHALL accept a word on any rising edge with s_valid=1 and s_ready=1; no other word is accepted.
REQ-013 SHALL order a frame as N*N+N words: H row-major (r=0..N-1, c=0..N-1), then y[0..N-1]; default 72 words.
REQ-014 SHALL pack H(r,c) at bits WL*N*r+WL*c+WL-1 : WL*N*r+WL*c, and y[r] at bits WL*r+WL-1 : WL*r.
REQ-015 SHALL hold two frame banks (ping-pong), each with state EMPTY or FULL; wr_bank selects the fill target, rd_bank selects the presented bank.
REQ-016 SHALL keep a word counter 0..N*N+N-1 that increments per accepted word and wraps to 0 on the last word, marking wr_bank FULL and toggling wr_bank in the same edge.
REQ-017 SHALL drive s_ready=1 iff bank[wr_bank] is EMPTY.
REQ-018 SHALL drive frame_valid=1 iff bank[rd_bank] is FULL; Hmatrix_o/Yarray_o always reflect bank[rd_bank] contents and stay stable while frame_valid=1 and frame_ready=0.
REQ-019 SHALL, on frame_valid=1 and frame_ready=1, mark bank[rd_bank] EMPTY and toggle rd_bank.
REQ-020 SHALL have latency: last word accepted at edge t, read bank previously EMPTY -> frame_valid=1 after edge t.
REQ-021 SHALL, when a fill completion and a release occur on the same edge (different banks), apply both; no word or frame lost.
REQ-022 SHALL, when both banks are FULL, hold s_ready=0 until a release; the freed bank accepts a word the following cycle.
REQ-023 SHALL sustain one word per cycle when frame_ready is held 1 (no bubbles between frames).
REQ-024 SHALL pass data bit-exact; no arithmetic, saturation or sign change.

Reset
REQ-025 SHALL, on rst=0 (asynchronous, including mid-frame), clear counter, wr_bank, rd_bank to 0, both banks EMPTY, err to 0; partial frame discarded.
REQ-026 SHALL have output reset values s_ready=1, frame_valid=0, Hmatrix_o=0, Yarray_o=0 (bank storage reset to 0).

Configuration
REQ-027 SHALL, with macro FRAME_LAST_CHECK_EN defined, add ports s_last (input, 1, marks final word of frame) and err (output, 1, sticky framing error, cleared only by reset).
REQ-028 SHALL, with FRAME_LAST_CHECK_EN, on an accepted word where s_last disagrees with (counter==N*N+N-1): set err, reset counter to 0, leave wr_bank EMPTY (frame discarded).
REQ-029 SHALL, without FRAME_LAST_CHECK_EN, have neither port and frame by count only.

Verification
REQ-030 SHALL cover: reset, stream words 1..72 back-to-back, frame_ready=1 -> frame_valid after edge of word 72, H(0,0)=1, H(7,7)=64, y[0]=65, y[7]=72, released next cycle.
REQ-031 SHALL cover: frame_ready=0, stream 144 words -> two frames stored, s_ready=0 at word 145; raise frame_ready -> second frame presented (H(0,0)=73), s_ready=1.
REQ-032 SHALL cover: negative data 16'h8000 and 16'hFFFF at H(3,5), y[2] -> identical bits at packed offsets 16*(8*3+5) and 16*2.
REQ-033 SHALL cover: rst=0 asserted after word 40 -> frame_valid stays 0; new 72-word frame is presented with word 1 at H(0,0).
REQ-034 SHALL cover: same-edge completion of frame 2 and release of frame 1 -> frame_valid remains 1 with frame 2 data, no gap.
REQ-035 SHALL cover (FRAME_LAST_CHECK_EN): s_last=1 on word 50 -> err=1, no frame_valid; following clean 72-word frame presented normally, err stays 1.
